// File: rtl/d_ff_sync_pkg.sv
// Shared limits and elaboration-time parameter checks for the d_ff_sync register primitive.
package d_ff_sync_pkg;

  localparam int DFF_MIN_WIDTH = 1;
  localparam int DFF_MIN_DEPTH = 1;

  function automatic bit dff_width_ok(input int width);
    return width >= DFF_MIN_WIDTH;
  endfunction

  function automatic bit dff_params_ok(input int width, input int depth);
    return dff_width_ok(width) && (depth >= DFF_MIN_DEPTH);
  endfunction

endpackage

// File: rtl/d_ff_stage.sv
// Single WIDTH-bit register with synchronous reset and capture enable.
// Latency one edge; en=0 holds the stored value, rst overrides en.
module d_ff_stage
  import d_ff_sync_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!dff_width_ok(WIDTH)) begin : g_bad_width
    $error("d_ff_stage: WIDTH must be >= 1");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_ff_sync.sv
// Cascade of DEPTH register stages: din_d emerges on dout_q DEPTH-1 edges after capture.
// en=0 freezes every stage without loss; rst reloads every stage with RST_VAL.
module d_ff_sync
  import d_ff_sync_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din_d,
  output logic [WIDTH-1:0] dout_q
);

  if (!dff_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("d_ff_sync: WIDTH and DEPTH must both be >= 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  // All stages share rst/en so the whole line shifts, holds or clears as one.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      d_ff_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (din_d),
        .q   (stage_q[k])
      );
    end else begin : g_tail
      d_ff_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (stage_q[k-1]),
        .q   (stage_q[k])
      );
    end
  end

  assign dout_q = stage_q[DEPTH-1];

endmodule

// File: tb/tb_d_ff_sync.sv
// Bench for d_ff_sync: a single-bit flop and an 8-bit, 3-deep delay line, scoreboard-checked.
module tb_d_ff_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, en_a = 1'b1;
  logic [0:0] din_a = 1'b0;
  logic [0:0] dout_a;

  logic       rst_b = 1'b0, en_b = 1'b1;
  logic [7:0] din_b = 8'h00;
  logic [7:0] dout_b;

  int checks = 0;
  int errors = 0;

  d_ff_sync #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_bit (
    .clk    (clk),
    .rst    (rst_a),
    .en     (en_a),
    .din_d  (din_a),
    .dout_q (dout_a)
  );

  d_ff_sync #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dly (
    .clk    (clk),
    .rst    (rst_b),
    .en     (en_b),
    .din_d  (din_b),
    .dout_q (dout_b)
  );

  // Reference model: pushes the expected output of every edge onto a scoreboard queue.
  logic [0:0] mdl_a;
  logic [7:0] mdl_b [3];
  logic [0:0] exp_a_q [$];
  logic [7:0] exp_b_q [$];

  always @(posedge clk) begin
    if (rst_a) mdl_a = 1'b0;
    else if (en_a) mdl_a = din_a;
    exp_a_q.push_back(mdl_a);
    if (rst_b) begin
      for (int i = 0; i < 3; i++) mdl_b[i] = 8'hA5;
    end else if (en_b) begin
      mdl_b[2] = mdl_b[1];
      mdl_b[1] = mdl_b[0];
      mdl_b[0] = din_b;
    end
    exp_b_q.push_back(mdl_b[2]);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [0:0] e;
    @(negedge clk);
    rst_a = 1'b1; en_a = 1'b1; din_a = 1'b1;
    exp_a_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: dout_q=%b required 0", i, dout_a);
      end
      e = exp_a_q.pop_front();
      checks++;
      if (dout_a !== e) begin
        errors++;
        $display("FAIL reset_sb[%0d]: dout_q=%b required %b", i, dout_a, e);
      end
    end
    @(negedge clk);
    checks++;
    if (dout_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: dout_q=%b required 0", dout_a);
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
    e = exp_a_q.pop_front();
    checks++;
    if (dout_a !== 1'b1 || dout_a !== e) begin
      errors++;
      $display("FAIL reset_release: dout_q=%b required 1 (model %b)", dout_a, e);
    end
  endtask

  task automatic test_bit_sequence();
    logic seq [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    rst_a = 1'b0; en_a = 1'b1;
    exp_a_q.delete();
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          din_a = seq[i];
          #12;
        end
      end
      begin
        for (int n = 0; n < 8; n++) begin
          logic [0:0] s;
          logic [0:0] e;
          @(posedge clk);
          s = din_a;
          #1;
          e = exp_a_q.pop_front();
          checks++;
          if (dout_a !== s || dout_a !== e) begin
            errors++;
            $display("FAIL seq_edge[%0d]: dout_q=%b required %b (model %b)", n, dout_a, s, e);
          end
          #3;
          checks++;
          if (dout_a !== s) begin
            errors++;
            $display("FAIL seq_midcycle[%0d]: dout_q=%b required %b", n, dout_a, s);
          end
        end
      end
    join
  endtask

  task automatic test_enable_hold();
    logic [0:0] e;
    @(negedge clk);
    en_a = 1'b1; din_a = 1'b1;
    exp_a_q.delete();
    @(posedge clk); #1;
    e = exp_a_q.pop_front();
    checks++;
    if (dout_a !== 1'b1 || dout_a !== e) begin
      errors++;
      $display("FAIL hold_load: dout_q=%b required 1", dout_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en_a = 1'b0; din_a = ~din_a;
      @(posedge clk); #1;
      e = exp_a_q.pop_front();
      checks++;
      if (dout_a !== 1'b1 || dout_a !== e) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: dout_q=%b required 1", i, dout_a);
      end
    end
    @(negedge clk);
    en_a = 1'b1; din_a = 1'b0;
    @(posedge clk); #1;
    e = exp_a_q.pop_front();
    checks++;
    if (dout_a !== 1'b0 || dout_a !== e) begin
      errors++;
      $display("FAIL hold_resume: dout_q=%b required 0", dout_a);
    end
  endtask

  task automatic test_reset_sync();
    @(negedge clk);
    en_a = 1'b1; din_a = 1'b1;
    @(posedge clk); #2;
    rst_a = 1'b1;
    #3;
    rst_a = 1'b0;
    #1;
    checks++;
    if (dout_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_glitch_mid: dout_q=%b required 1", dout_a);
    end
    @(posedge clk); #1;
    checks++;
    if (dout_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_glitch_edge: dout_q=%b required 1", dout_a);
    end
    @(negedge clk);
    rst_a = 1'b1; en_a = 1'b1; din_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dout_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority: dout_q=%b required 0", dout_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_delay_line();
    logic [7:0] ins  [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    logic [7:0] outs [5] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};
    logic [7:0] ins2 [3] = '{8'h20, 8'h21, 8'h22};
    logic [7:0] e;
    @(negedge clk);
    rst_b = 1'b1; en_b = 1'b1; din_b = 8'hFF;
    exp_b_q.delete();
    @(posedge clk); #1;
    e = exp_b_q.pop_front();
    checks++;
    if (dout_b !== 8'hA5 || dout_b !== e) begin
      errors++;
      $display("FAIL dly_reset: dout_q=%h required a5", dout_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din_b = ins[i];
      @(posedge clk); #1;
      e = exp_b_q.pop_front();
      checks++;
      if (dout_b !== outs[i] || dout_b !== e) begin
        errors++;
        $display("FAIL dly_flow[%0d]: dout_q=%h required %h (model %h)", i, dout_b, outs[i], e);
      end
      @(negedge clk);
    end
    // Freeze with data in flight, then reset while it is still in the pipe.
    din_b = 8'h10;
    @(posedge clk); #1;
    void'(exp_b_q.pop_front());
    @(negedge clk);
    en_b = 1'b0; din_b = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = exp_b_q.pop_front();
      checks++;
      if (dout_b !== 8'h00 || dout_b !== e) begin
        errors++;
        $display("FAIL dly_hold[%0d]: dout_q=%h required 00 (model %h)", i, dout_b, e);
      end
      @(negedge clk);
    end
    en_b = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
    e = exp_b_q.pop_front();
    checks++;
    if (dout_b !== 8'hA5 || dout_b !== e) begin
      errors++;
      $display("FAIL dly_midreset: dout_q=%h required a5", dout_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_b = ins2[i];
      @(posedge clk); #1;
      e = exp_b_q.pop_front();
      checks++;
      if (dout_b !== ((i < 2) ? 8'hA5 : 8'h20) || dout_b !== e) begin
        errors++;
        $display("FAIL dly_after_reset[%0d]: dout_q=%h (model %h)", i, dout_b, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_bit_sequence();
    test_enable_hold();
    test_reset_sync();
    test_delay_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
